// File: rtl/branch_seq_pkg.sv
// Shared definitions for the miniRISC branch sequencer: op codes, FSM states
// and the taken-evaluation function used by decode-side checks as well.
package branch_seq_pkg;

  typedef enum logic [2:0] {
    OP_BR   = 3'd0,
    OP_BZ   = 3'd1,
    OP_BNZ  = 3'd2,
    OP_BMI  = 3'd3,
    OP_BPL  = 3'd4,
    OP_CALL = 3'd5,
    OP_RET  = 3'd6,
    OP_RSVD = 3'd7
  } br_op_t;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    REDIRECT = 2'd1,
    FLUSH    = 2'd2
  } state_t;

  function automatic logic br_taken(input br_op_t op, input logic z, input logic n);
    logic taken;
    case (op)
      OP_BR, OP_CALL, OP_RET: taken = 1'b1;
      OP_BZ:                  taken = z;
      OP_BNZ:                 taken = ~z;
      OP_BMI:                 taken = n;
      OP_BPL:                 taken = ~n;
      default:                taken = 1'b0;
    endcase
    return taken;
  endfunction

endpackage

// File: rtl/branch_ras.sv
// Circular return-address stack; a push when full overwrites the oldest entry.
// Overflow/underflow indications are sticky until reset.
module branch_ras #(
  parameter int W     = 32,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] push_data,
  output logic         full,
  output logic         empty,
  output logic [W-1:0] top,
  output logic         ovf,
  output logic         unf
);
  import branch_seq_pkg::*;

  localparam int PTR_W = $clog2(DEPTH);

  logic [W-1:0]   mem_r [DEPTH];
  logic [PTR_W-1:0] wp_r;
  logic [PTR_W:0]   cnt_r;

  assign full  = (cnt_r == (PTR_W+1)'(DEPTH));
  assign empty = (cnt_r == '0);
  assign top   = mem_r[wp_r - PTR_W'(1)];

  // Stack storage, write pointer, occupancy and sticky error bits.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem_r[i] <= '0;
      wp_r  <= '0;
      cnt_r <= '0;
      ovf   <= 1'b0;
      unf   <= 1'b0;
    end else if (push) begin
      mem_r[wp_r] <= push_data;
      wp_r        <= wp_r + PTR_W'(1);
      if (full) ovf <= 1'b1;
      else      cnt_r <= cnt_r + (PTR_W+1)'(1);
    end else if (pop) begin
      if (empty) begin
        unf <= 1'b1;
      end else begin
        wp_r  <= wp_r - PTR_W'(1);
        cnt_r <= cnt_r - (PTR_W+1)'(1);
      end
    end
  end

endmodule

// File: rtl/branch_sequencer.sv
// Branch path control: flag register, branch resolution, PC redirect handshake
// and post-redirect fetch flush. Optional return-address stack via BR_RAS_EN.
module branch_sequencer #(
  parameter int ADDR_W       = 32,
  parameter int INSTR_BYTES  = 4,
  parameter int FLUSH_CYCLES = 1,
  parameter int RAS_DEPTH    = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              alu_flag_we,
  input  logic              alu_zero,
  input  logic              alu_msb,
  input  logic              br_valid,
  output logic              br_ready,
  input  logic [2:0]        br_op,
  input  logic [ADDR_W-1:0] br_pc,
  input  logic [ADDR_W-1:0] br_target,
  output logic              pc_load,
  input  logic              pc_ready,
  output logic [ADDR_W-1:0] pc_load_addr,
  output logic              flush,
  output logic              link_we,
  output logic [ADDR_W-1:0] link_addr,
  output logic              ras_ovf,
  output logic              ras_unf
);
  import branch_seq_pkg::*;

  state_t      state_r;
  logic [3:0]  cnt_r;
  logic        flag_z_r, flag_n_r;
  logic        z_s, n_s, accept_s, taken_s, is_call_s, is_ret_s;
  logic [ADDR_W-1:0] link_s, target_s;
  br_op_t      op_s;

  assign op_s      = br_op_t'(br_op);
  assign z_s       = alu_flag_we ? alu_zero : flag_z_r;
  assign n_s       = alu_flag_we ? alu_msb  : flag_n_r;
  assign accept_s  = br_valid & br_ready;
  assign taken_s   = br_taken(op_s, z_s, n_s);
  assign is_call_s = accept_s & (op_s == OP_CALL);
  assign is_ret_s  = accept_s & (op_s == OP_RET);
  assign link_s    = br_pc + ADDR_W'(INSTR_BYTES);

`ifdef BR_RAS_EN
  logic              ras_full_s, ras_empty_s;
  logic [ADDR_W-1:0] ras_top_s;

  branch_ras #(.W(ADDR_W), .DEPTH(RAS_DEPTH)) u_ras (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (is_call_s),
    .pop       (is_ret_s),
    .push_data (link_s),
    .full      (ras_full_s),
    .empty     (ras_empty_s),
    .top       (ras_top_s),
    .ovf       (ras_ovf),
    .unf       (ras_unf)
  );

  // Returns follow the stack unless it is empty, then fall back to the register value.
  always_comb begin
    target_s = br_target;
    if (is_ret_s && !ras_empty_s) target_s = ras_top_s;
    else                          target_s = br_target;
  end
`else
  logic [31:0] unused_ras_depth_s;
  assign unused_ras_depth_s = 32'(RAS_DEPTH);
  assign target_s = br_target;
  assign ras_ovf  = 1'b0;
  assign ras_unf  = 1'b0;
`endif

  // Flag register, link pulse and redirect FSM with registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r      <= IDLE;
      cnt_r        <= 4'd0;
      flag_z_r     <= 1'b0;
      flag_n_r     <= 1'b0;
      br_ready     <= 1'b1;
      pc_load      <= 1'b0;
      pc_load_addr <= '0;
      flush        <= 1'b0;
      link_we      <= 1'b0;
      link_addr    <= '0;
    end else begin
      if (alu_flag_we) begin
        flag_z_r <= alu_zero;
        flag_n_r <= alu_msb;
      end
      link_we <= is_call_s;
      if (is_call_s) link_addr <= link_s;
      case (state_r)
        IDLE: begin
          if (accept_s && taken_s) begin
            state_r      <= REDIRECT;
            pc_load_addr <= target_s;
            pc_load      <= 1'b1;
            flush        <= 1'b1;
            br_ready     <= 1'b0;
          end
        end
        REDIRECT: begin
          if (pc_ready) begin
            pc_load <= 1'b0;
            if (FLUSH_CYCLES == 0) begin
              state_r  <= IDLE;
              flush    <= 1'b0;
              br_ready <= 1'b1;
            end else begin
              state_r <= FLUSH;
              cnt_r   <= 4'(FLUSH_CYCLES);
            end
          end
        end
        FLUSH: begin
          if (cnt_r <= 4'd1) begin
            state_r  <= IDLE;
            flush    <= 1'b0;
            br_ready <= 1'b1;
          end else begin
            cnt_r <= cnt_r - 4'd1;
          end
        end
        default: begin
          state_r  <= IDLE;
          pc_load  <= 1'b0;
          flush    <= 1'b0;
          br_ready <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_branch_sequencer.sv
// Directed self-checking bench for branch_sequencer (default FLUSH_CYCLES=1);
// the stack scenario runs when BR_RAS_EN is defined.
module tb_branch_sequencer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        alu_flag_we, alu_zero, alu_msb;
  logic        br_valid, br_ready;
  logic [2:0]  br_op;
  logic [31:0] br_pc, br_target;
  logic        pc_load, pc_ready, flush, link_we, ras_ovf, ras_unf;
  logic [31:0] pc_load_addr, link_addr;

  int tests = 0;
  int fails = 0;

  branch_sequencer dut (
    .clk(clk), .rst_n(rst_n), .alu_flag_we(alu_flag_we), .alu_zero(alu_zero),
    .alu_msb(alu_msb), .br_valid(br_valid), .br_ready(br_ready), .br_op(br_op),
    .br_pc(br_pc), .br_target(br_target), .pc_load(pc_load), .pc_ready(pc_ready),
    .pc_load_addr(pc_load_addr), .flush(flush), .link_we(link_we),
    .link_addr(link_addr), .ras_ovf(ras_ovf), .ras_unf(ras_unf)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // One-cycle branch presentation; returns with br_valid dropped.
  task automatic issue(input logic [2:0] op, input logic [31:0] pc, input logic [31:0] tgt);
    br_valid = 1'b1; br_op = op; br_pc = pc; br_target = tgt;
    tick();
    br_valid = 1'b0;
  endtask

  // Acknowledge a pending redirect and let the single flush cycle drain.
  task automatic ack();
    pc_ready = 1'b1;
    tick();
    pc_ready = 1'b0;
    tick();
  endtask

  task automatic set_flags(input logic z, input logic n);
    alu_flag_we = 1'b1; alu_zero = z; alu_msb = n;
    tick();
    alu_flag_we = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; alu_flag_we = 1'b0; alu_zero = 1'b0; alu_msb = 1'b0;
    br_valid = 1'b0; br_op = 3'd0; br_pc = 32'h0; br_target = 32'h0; pc_ready = 1'b0;
    #12;
    chk("rst_br_ready", 32'(br_ready), 32'd1);
    chk("rst_pc_load", 32'(pc_load), 32'd0);
    chk("rst_flush", 32'(flush), 32'd0);
    chk("rst_link_we", 32'(link_we), 32'd0);
    rst_n = 1'b1;
    tick();

    // 1: BZ after Z set -> one pc_load cycle, two flush cycles
    set_flags(1'b1, 1'b0);
    issue(3'd1, 32'h80, 32'h100);
    chk("t1_pc_load", 32'(pc_load), 32'd1);
    chk("t1_addr", pc_load_addr, 32'h100);
    chk("t1_flush_a", 32'(flush), 32'd1);
    chk("t1_ready_lo", 32'(br_ready), 32'd0);
    pc_ready = 1'b1;
    tick();
    pc_ready = 1'b0;
    chk("t1_pc_load_off", 32'(pc_load), 32'd0);
    chk("t1_flush_b", 32'(flush), 32'd1);
    tick();
    chk("t1_flush_end", 32'(flush), 32'd0);
    chk("t1_ready_back", 32'(br_ready), 32'd1);

    // 2: BNZ with Z=1 and reserved op are ignored
    issue(3'd2, 32'h84, 32'h200);
    chk("t2_bnz_load", 32'(pc_load), 32'd0);
    chk("t2_bnz_flush", 32'(flush), 32'd0);
    chk("t2_bnz_ready", 32'(br_ready), 32'd1);
    issue(3'd7, 32'h88, 32'h204);
    chk("t2_rsvd_load", 32'(pc_load), 32'd0);
    chk("t2_rsvd_link", 32'(link_we), 32'd0);
    chk("t2_rsvd_ready", 32'(br_ready), 32'd1);

    // 3: BMI in the same cycle that N becomes 1
    alu_flag_we = 1'b1; alu_zero = 1'b0; alu_msb = 1'b1;
    issue(3'd3, 32'h8c, 32'h240);
    alu_flag_we = 1'b0;
    chk("t3_bypass_load", 32'(pc_load), 32'd1);
    chk("t3_bypass_addr", pc_load_addr, 32'h240);
    ack();

    // 4: BR with a three-cycle stall on pc_ready
    issue(3'd0, 32'h90, 32'h300);
    for (int i = 0; i < 3; i++) begin
      chk("t4_stall_load", 32'(pc_load), 32'd1);
      chk("t4_stall_addr", pc_load_addr, 32'h300);
      chk("t4_stall_ready", 32'(br_ready), 32'd0);
      chk("t4_stall_flush", 32'(flush), 32'd1);
      tick();
    end
    pc_ready = 1'b1;
    tick();
    pc_ready = 1'b0;
    chk("t4_ack_flush", 32'(flush), 32'd1);
    chk("t4_ack_load", 32'(pc_load), 32'd0);
    tick();
    chk("t4_done_flush", 32'(flush), 32'd0);

    // CALL link pulse, then RET
    issue(3'd5, 32'h10, 32'h400);
    chk("call_link_we", 32'(link_we), 32'd1);
    chk("call_link_addr", link_addr, 32'h14);
    chk("call_addr", pc_load_addr, 32'h400);
    ack();
    chk("call_link_pulse", 32'(link_we), 32'd0);
    issue(3'd6, 32'h404, 32'h500);
`ifdef BR_RAS_EN
    chk("ret_addr", pc_load_addr, 32'h14);
`else
    chk("ret_addr", pc_load_addr, 32'h500);
`endif
    ack();
    chk("ret_unf", 32'(ras_unf), 32'd0);

`ifdef BR_RAS_EN
    // 5: overflow then underflow on a 4-deep stack
    for (int i = 1; i <= 5; i++) begin
      issue(3'd5, 32'(i * 16), 32'h1000);
      ack();
    end
    chk("t5_ovf", 32'(ras_ovf), 32'd1);
    for (int i = 5; i >= 2; i--) begin
      issue(3'd6, 32'h1000, 32'h200);
      chk("t5_ret_addr", pc_load_addr, 32'(i * 16 + 4));
      ack();
    end
    chk("t5_unf_pre", 32'(ras_unf), 32'd0);
    issue(3'd6, 32'h1000, 32'h200);
    chk("t5_ret_empty", pc_load_addr, 32'h200);
    chk("t5_unf", 32'(ras_unf), 32'd1);
    ack();
`else
    chk("ovf_tied", 32'(ras_ovf), 32'd0);
`endif

    // 6: async reset in the middle of a redirect
    set_flags(1'b1, 1'b1);
    issue(3'd0, 32'h600, 32'h600);
    chk("t6_pre_load", 32'(pc_load), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("t6_rst_load", 32'(pc_load), 32'd0);
    chk("t6_rst_flush", 32'(flush), 32'd0);
    tick();
    rst_n = 1'b1;
    tick();
    chk("t6_ready", 32'(br_ready), 32'd1);
    issue(3'd1, 32'h604, 32'h700);
    chk("t6_z_cleared", 32'(pc_load), 32'd0);
    issue(3'd4, 32'h608, 32'h780);
    chk("t6_n_cleared", 32'(pc_load), 32'd1);
    chk("t6_n_addr", pc_load_addr, 32'h780);
    ack();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
